// File: rtl/forward_sequencer.sv
// forward_sequencer: turns FORWARD/HALT instructions into MAC array strobes.
// Define SEQ_PREFETCH_EN to add a one-entry instruction buffer.
module forward_sequencer #(
   parameter int XY_MEM_DEPTH = 8,
   parameter int W_MEM_DEPTH  = 10,
   parameter int MOV_LENGTH   = 8,
   parameter int OPCODE_W     = 2,
   parameter logic [OPCODE_W-1:0] INST_FORWARD = OPCODE_W'(1),
   parameter logic [OPCODE_W-1:0] INST_HALT    = OPCODE_W'(2)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    inst_valid,
   output logic                    inst_ready,
   input  logic [OPCODE_W-1:0]     inst_opcode,
   input  logic [XY_MEM_DEPTH-1:0] inst_x_addr,
   input  logic [XY_MEM_DEPTH-1:0] inst_y_addr,
   input  logic [W_MEM_DEPTH-1:0]  inst_w_addr,
   input  logic [MOV_LENGTH-1:0]   inst_length0,
   input  logic [MOV_LENGTH-1:0]   inst_length1,
   output logic [XY_MEM_DEPTH-1:0] xy_read_addr,
   output logic [W_MEM_DEPTH-1:0]  w_read_addr,
   output logic                    mac_en,
   output logic                    mac_clear,
   output logic [XY_MEM_DEPTH-1:0] xy_write_addr,
   output logic                    xy_write_en,
   output logic                    busy,
   output logic                    done,
   output logic                    halted
);

   typedef struct packed {
      logic [OPCODE_W-1:0]     op;
      logic [XY_MEM_DEPTH-1:0] x;
      logic [XY_MEM_DEPTH-1:0] y;
      logic [W_MEM_DEPTH-1:0]  w;
      logic [MOV_LENGTH-1:0]   l0;
      logic [MOV_LENGTH-1:0]   l1;
   } inst_t;

   typedef enum logic [2:0] {
      S_IDLE, S_ACC, S_WB, S_DONE, S_HALT
   } state_t;

   state_t                  state;
   logic [XY_MEM_DEPTH-1:0] x_nxt;
   logic [XY_MEM_DEPTH-1:0] y_nxt;
   logic [W_MEM_DEPTH-1:0]  w_nxt;
   logic [MOV_LENGTH-1:0]   cnt;
   logic [MOV_LENGTH-1:0]   l1_r;

   inst_t in_w;
   inst_t src;
   logic  accept;
   logic  go;

`ifdef SEQ_PREFETCH_EN
   inst_t buf_q;
   logic  buf_v;
`endif

   // Pick the instruction to launch: the port in IDLE, buffer or port in DONE.
   always_comb begin
      in_w   = '{op: inst_opcode, x: inst_x_addr, y: inst_y_addr,
                 w: inst_w_addr, l0: inst_length0, l1: inst_length1};
      accept = inst_valid & inst_ready;
      src    = in_w;
      go     = accept && (state == S_IDLE);
`ifdef SEQ_PREFETCH_EN
      if (state == S_DONE) begin
         go  = buf_v | accept;
         src = buf_v ? buf_q : in_w;
      end
`endif
   end

   // Sequencer FSM with registered address and strobe outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_IDLE;
         inst_ready    <= 1'b0;
         xy_read_addr  <= '0;
         w_read_addr   <= '0;
         xy_write_addr <= '0;
         mac_en        <= 1'b0;
         mac_clear     <= 1'b0;
         xy_write_en   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         halted        <= 1'b0;
         x_nxt         <= '0;
         y_nxt         <= '0;
         w_nxt         <= '0;
         cnt           <= '0;
         l1_r          <= '0;
`ifdef SEQ_PREFETCH_EN
         buf_q         <= '0;
         buf_v         <= 1'b0;
`endif
      end else begin
         mac_clear <= 1'b0;
         done      <= 1'b0;
         unique case (state)
            S_IDLE: inst_ready <= 1'b1;
            S_ACC: begin
               if (cnt != '0) begin
                  cnt          <= cnt - 1'b1;
                  xy_read_addr <= x_nxt;
                  w_read_addr  <= w_nxt;
                  x_nxt        <= x_nxt + 1'b1;
                  w_nxt        <= w_nxt + 1'b1;
               end else begin
                  mac_en <= 1'b0;
                  if (l1_r != '0) begin
                     state         <= S_WB;
                     xy_write_en   <= 1'b1;
                     xy_write_addr <= y_nxt;
                     y_nxt         <= y_nxt + 1'b1;
                     cnt           <= l1_r - 1'b1;
                  end else begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            S_WB: begin
               if (cnt != '0) begin
                  cnt           <= cnt - 1'b1;
                  xy_write_addr <= y_nxt;
                  y_nxt         <= y_nxt + 1'b1;
               end else begin
                  xy_write_en <= 1'b0;
                  state       <= S_DONE;
                  done        <= 1'b1;
               end
            end
            S_DONE: begin
               state      <= S_IDLE;
               busy       <= 1'b0;
               inst_ready <= 1'b1;
            end
            S_HALT: inst_ready <= 1'b0;
            default: state <= S_IDLE;
         endcase

`ifdef SEQ_PREFETCH_EN
         if (accept && (state == S_ACC || state == S_WB) &&
             (inst_opcode == INST_FORWARD ||
              inst_opcode == INST_HALT)) begin
            buf_q      <= in_w;
            buf_v      <= 1'b1;
            inst_ready <= 1'b0;
         end
         if (go) buf_v <= 1'b0;
`endif

         if (go) begin
            if (src.op == INST_FORWARD) begin
               busy  <= 1'b1;
`ifdef SEQ_PREFETCH_EN
               inst_ready <= 1'b1;
`else
               inst_ready <= 1'b0;
`endif
               y_nxt <= src.y;
               l1_r  <= src.l1;
               if (src.l0 != '0) begin
                  state        <= S_ACC;
                  mac_en       <= 1'b1;
                  mac_clear    <= 1'b1;
                  xy_read_addr <= src.x;
                  w_read_addr  <= src.w;
                  x_nxt        <= src.x + 1'b1;
                  w_nxt        <= src.w + 1'b1;
                  cnt          <= src.l0 - 1'b1;
               end else if (src.l1 != '0) begin
                  state         <= S_WB;
                  xy_write_en   <= 1'b1;
                  xy_write_addr <= src.y;
                  y_nxt         <= src.y + 1'b1;
                  cnt           <= src.l1 - 1'b1;
               end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end else if (src.op == INST_HALT) begin
               state      <= S_HALT;
               halted     <= 1'b1;
               busy       <= 1'b0;
               inst_ready <= 1'b0;
            end
         end
      end
   end

endmodule
